// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton conditioner: button indices, channel
// count, debounce FSM state encoding and a width helper.
package btn_pkg;

  localparam int NUM_BTN = 5;

  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_RISE_WAIT = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_WAIT = 2'd3;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM with stable-cycle
// counter and press pulse. Auto-repeat exists only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
  localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             sync;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;
  logic             pulse_d;

  // NOTE: the synchronizer flops take the async reset too, so a button held
  // through reset is seen as a fresh rising edge once reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], raw};
  end

  assign sync = sync_q[1];

  // NOTE: next-state and counter get defaults first so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_LOW: begin
        if (sync) begin
          state_d = ST_RISE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_RISE_WAIT: begin
        if (!sync) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!sync) begin
          state_d = ST_FALL_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      ST_FALL_WAIT: begin
        if (sync) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == DB_LIMIT) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  assign press = (state_q == ST_RISE_WAIT) && (state_d == ST_HIGH);

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt_q;
  logic             rep_first_q;
  logic             rep_run;
  logic             rep_due;

  // The schedule only advances while settled in HIGH; FALL_WAIT freezes it.
  assign rep_run = (state_q == ST_HIGH) && sync;
  assign rep_due = rep_run && (rep_cnt_q == (rep_first_q ? RD_LAST : RP_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (press) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (rep_due) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else if (rep_run) begin
      rep_cnt_q   <= rep_cnt_q + CNT_W'(1);
    end
  end

  assign pulse_d = press || rep_due;
`else
  assign pulse_d = press;
`endif

  // Outputs are registered from the next state so they move on the same edge as the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
      pulse   <= pulse_d;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Five independent debounced pushbutton channels (index order c, l, u, r, d).
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat pulses.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; expectations follow BTN_AUTOREPEAT_EN when it is defined.
module tb_btn_conditioner;

`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] raw;
    logic [4:0] level;
    logic [4:0] pulse;
  } vec_t;

  vec_t vecs [28];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [4:0] actual, input logic [4:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Apply raw for the next edge, then look at outputs 1 time unit after it.
  task automatic tick(input logic [4:0] r);
    btn_raw = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // c and l pressed from edge 0; u and r join at edge 12; all released at edge 20.
    for (int e = 0; e < 28; e++) begin
      vecs[e].raw   = (e < 12) ? 5'b00011 : (e < 20) ? 5'b01111 : 5'b00000;
      vecs[e].level = (e < 6)  ? 5'b00000 : (e < 18) ? 5'b00011 :
                      (e < 26) ? 5'b01111 : 5'b00000;
      vecs[e].pulse = 5'b00000;
    end
    vecs[6].pulse  = 5'b00011;
    vecs[18].pulse = 5'b01100;
    if (AR) begin
      vecs[16].pulse = 5'b00011;
      vecs[19].pulse = 5'b00011;
    end

    rst     = 1'b1;
    btn_raw = 5'b00000;
    #3;
    check("reset_level", btn_level, 5'b00000);
    check("reset_pulse", btn_pulse, 5'b00000);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (4) tick(5'b00000);

    for (int e = 0; e < 28; e++) begin
      tick(vecs[e].raw);
      check($sformatf("table_level_e%0d", e), btn_level, vecs[e].level);
      check($sformatf("table_pulse_e%0d", e), btn_pulse, vecs[e].pulse);
    end
    repeat (4) tick(5'b00000);

    // Bounce on d: never more than 2 consecutive high cycles.
    for (int e = 0; e < 16; e++) begin
      logic [4:0] r;
      r = (e < 8 && (e % 4) < 2) ? 5'b10000 : 5'b00000;
      tick(r);
      check($sformatf("bounce_e%0d", e), {btn_level[4], btn_pulse}, 5'b0);
      // Upper bits of the packed compare carry btn_pulse[4:1]; any stray pulse shows up.
    end

    // Reset mid RISE_WAIT on r, with c already debounced high.
    repeat (7) tick(5'b00001);
    check("pre_rst_level", btn_level, 5'b00001);
    repeat (4) tick(5'b01001);
    #3 rst = 1'b1;
    #1;
    check("rst_async_level", btn_level, 5'b00000);
    check("rst_async_pulse", btn_pulse, 5'b00000);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_pulse_e%0d", e), btn_pulse, (e == 6) ? 5'b01001 : 5'b00000);
      check($sformatf("post_rst_level_e%0d", e), btn_level, (e >= 6) ? 5'b01001 : 5'b00000);
    end
    repeat (8) tick(5'b00000);

    // d held for 30 edges: press pulse at 6, repeats only with auto-repeat enabled.
    for (int e = 0; e <= 30; e++) begin
      logic exp_p;
      exp_p = (e == 6) ||
              (AR && (e == 16 || e == 19 || e == 22 || e == 25 || e == 28));
      tick((e < 30) ? 5'b10000 : 5'b00000);
      check($sformatf("hold_d_pulse_e%0d", e), btn_pulse, {exp_p, 4'b0000});
    end
    repeat (8) tick(5'b00000);
    check("final_idle_level", btn_level, 5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
